clk_rst_seq: RTL
================

# clk_rst_seq

Parametrised clock-domain reset sequencer driven from the free-running board reference clock. It controls the reset pin of a PLL/MMCM primitive, qualifies that primitive's `locked` status, and releases `NUM_RST` downstream active-high resets in a fixed staged order. It re-runs the whole sequence automatically on lock loss or lock timeout. It sits beside the clock-generation primitive at the top level, and its outputs feed the per-domain reset synchronisers.

## Interface
- `NUM_RST`, 4: number of staged reset outputs, ≥1.
- `LOCK_FILTER`, 64: consecutive synchronised-high `locked` cycles required before release, ≥1.
- `STAGE_DLY`, 16: cycles between successive reset releases, ≥1.
- `LOCK_TIMEOUT`, 4096: maximum cycles in WAIT_LOCK before the PLL reset is re-pulsed; must exceed `LOCK_FILTER`+2.
- `PLL_RST_CYCLES`, 8: width of the PLL reset pulse in cycles, ≥1.
- `CNT_W`, 8: width of the lock-loss counter.

Ports:
- `clk_in1`, in, 1: free-running reference clock, the only clock.
- `reset`, in, 1: asynchronous, active-high block reset.
- `locked`, in, 1: PLL lock status; asynchronous to `clk_in1`.
- `sw_rst_req`, in, 1: single-cycle soft reset request.
- `pll_rst`, out, 1: active-high reset to the PLL primitive.
- `rst_out`, out, `NUM_RST`: active-high staged resets; bit 0 releases first.
- `all_released`, out, 1: high while every `rst_out` bit is low.
- `lock_loss_cnt`, out, `CNT_W`: saturating count of lock-loss events.

## Operation
- Synchronisation: `locked` passes through a 2-flop synchroniser. The state machine only ever observes `locked_s`.
- Reset values, held while `reset`=1:
  - `pll_rst`=1
  - `rst_out`=all ones
  - `all_released`=0
  - `lock_loss_cnt`=0
  - state = PLL_RST, all counters 0
- PLL_RST: hold `pll_rst`=1 for exactly `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK. `rst_out` stays all ones.
- WAIT_LOCK: `pll_rst`=0.
  - The filter counter increments while `locked_s`=1 and clears on any cycle with `locked_s`=0.
  - When the filter count reaches `LOCK_FILTER`, go to RELEASE.
  - The timeout counter runs from WAIT_LOCK entry. When it reaches `LOCK_TIMEOUT` without the filter completing, go to PLL_RST. A timeout does not increment `lock_loss_cnt`.
- RELEASE: `rst_out[k]` deasserts `(k+1)*STAGE_DLY` cycles after RELEASE entry. Once deasserted, a bit stays low. The cycle `rst_out[NUM_RST-1]` deasserts, `all_released` rises and the state becomes RUN.
- RUN: hold until lock loss or soft reset.
- Lock loss (`locked_s`=0 in RELEASE or RUN):
  - On the next edge, `rst_out`=all ones, `all_released`=0, and the state becomes PLL_RST with `pll_rst`=1.
  - `lock_loss_cnt` increments and saturates at all ones.
- Soft reset (`sw_rst_req`=1 in RELEASE or RUN):
  - On the next edge, `rst_out`=all ones, `all_released`=0, and the state becomes WAIT_LOCK. The PLL is not reset.
  - Filter and timeout counters restart from 0.
  - `sw_rst_req` is ignored in PLL_RST and WAIT_LOCK.
- Simultaneous lock loss and `sw_rst_req`: lock loss wins (PLL_RST, counter increments).
- `reset` asserted mid-sequence: every output returns to its reset value immediately (asynchronously).
- Deassertion of `reset` is treated as an asynchronous input. The first PLL_RST count cycle is the first `clk_in1` edge with `reset` low.

## Timing
- Every output is a registered flop output; there are no combinational paths from input to output.
- `locked` rise to RELEASE entry: 2 synchroniser cycles + `LOCK_FILTER` cycles.
- RELEASE entry to `all_released`: `NUM_RST*STAGE_DLY` cycles.
- `locked` fall to `rst_out` all ones: 3 edges (2 synchroniser + 1 state register).
- `sw_rst_req` to `rst_out` all ones: 1 edge.
- `rst_out` bits only ever transition 1→0 in index order, and 0→1 all together.

## Configuration
- `CLK_RST_SEQ_LOSS_CNT_EN` defined: the lock-loss counter is present as described above.
- `CLK_RST_SEQ_LOSS_CNT_EN` undefined: no counter flops are built, `lock_loss_cnt` is tied to 0, and all other behaviour is identical.

## Test plan
All scenarios use `NUM_RST`=3, `LOCK_FILTER`=4, `STAGE_DLY`=2, `LOCK_TIMEOUT`=20, `PLL_RST_CYCLES`=3.

- Cold start, PLL model asserts `locked` 5 cycles after `pll_rst` falls:
  - `pll_rst` high for exactly 3 cycles after `reset` release.
  - RELEASE entered 6 cycles after `locked` rises.
  - `rst_out` goes 111→110→100→000 at +2, +4 and +6 cycles; `all_released`=1 at +6.
- `locked` held low forever: `pll_rst` re-pulses for 3 cycles every 23 cycles, `rst_out` stays 111, `lock_loss_cnt` stays 0.
- Lock glitch in WAIT_LOCK (`locked` high 3 cycles, low 1, high): the filter restarts, and RELEASE is entered 4 synchronised-high cycles after the glitch.
- In RUN, drop `locked`:
  - `rst_out`=111 and `pll_rst`=1 three edges later; `lock_loss_cnt` 0→1.
  - Repeat 300 times with `CNT_W`=8: the count saturates at 255.
- `sw_rst_req` in the same cycle as `locked_s` falls during RELEASE: takes the lock-loss path (PLL_RST, count +1). `sw_rst_req` alone in RUN: `rst_out`=111 next edge, `pll_rst` stays 0, re-release after 4+6 cycles.
- `reset` asserted mid-RELEASE: all outputs return to their reset values asynchronously. Build with the macro undefined: `lock_loss_cnt`=0 after a lock loss.

Source files
------------

// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if: PLL status/control and staged reset bundle for clk_rst_seq.
// master is the sequencer side, slave is the PLL / reset-consumer side.
interface clk_rst_seq_if #(
    parameter int NUM_RST = 4,
    parameter int CNT_W   = 8
);
    logic               locked;
    logic               sw_rst_req;
    logic               pll_rst;
    logic [NUM_RST-1:0] rst_out;
    logic               all_released;
    logic [CNT_W-1:0]   lock_loss_cnt;
    modport master (input locked, sw_rst_req, output pll_rst, rst_out, all_released, lock_loss_cnt);
    modport slave (output locked, sw_rst_req, input pll_rst, rst_out, all_released, lock_loss_cnt);
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: PLL reset/lock qualifier releasing NUM_RST staged resets in index order.
// Define CLK_RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module clk_rst_seq #(
    parameter int NUM_RST        = 4,
    parameter int LOCK_FILTER    = 64,
    parameter int STAGE_DLY      = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input logic           clk_in1,
    input logic           reset,
    clk_rst_seq_if.master b
);
    localparam int REL_CYCLES = NUM_RST * STAGE_DLY;
    localparam int SEQ_MAX    = REL_CYCLES > PLL_RST_CYCLES ? REL_CYCLES : PLL_RST_CYCLES;
    localparam int SEQ_W      = $clog2(SEQ_MAX + 1);
    localparam int FILT_W     = $clog2(LOCK_FILTER + 1);
    localparam int TMO_W      = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN} state_t;

    state_t             state;
    logic               locked_m, locked_s;
    logic [SEQ_W-1:0]   seq_cnt, seq_nxt;
    logic [FILT_W-1:0]  filt_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               pll_rst_q, all_rel_q;
    logic [NUM_RST-1:0] rst_q;
    logic               active, loss;

    assign active  = state == RELEASE || state == RUN;
    assign loss    = active && !locked_s;
    assign seq_nxt = seq_cnt + SEQ_W'(1);

    always_ff @(posedge clk_in1 or posedge reset)
        if (reset) {locked_s, locked_m} <= '0;
        else {locked_s, locked_m} <= {locked_m, b.locked};

    // seq_cnt times the PLL reset pulse in PLL_RST and the release ladder in RELEASE
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state     <= PLL_RST;
            seq_cnt   <= '0;
            filt_cnt  <= '0;
            tmo_cnt   <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
        end else if (loss) begin
            state     <= PLL_RST;
            seq_cnt   <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
        end else if (active && b.sw_rst_req) begin
            state     <= WAIT_LOCK;
            filt_cnt  <= '0;
            tmo_cnt   <= '0;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    seq_cnt <= seq_nxt;
                    if (seq_cnt == SEQ_W'(PLL_RST_CYCLES - 1)) begin
                        state     <= WAIT_LOCK;
                        pll_rst_q <= 1'b0;
                        filt_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                WAIT_LOCK: begin
                    filt_cnt <= locked_s ? filt_cnt + FILT_W'(1) : '0;
                    tmo_cnt  <= tmo_cnt + TMO_W'(1);
                    // a completing filter takes priority over a coincident timeout
                    if (locked_s && filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
                        state   <= RELEASE;
                        seq_cnt <= '0;
                    end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        state     <= PLL_RST;
                        seq_cnt   <= '0;
                        pll_rst_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    seq_cnt <= seq_nxt;
                    for (int k = 0; k < NUM_RST; k++)
                        if (seq_nxt == SEQ_W'((k + 1) * STAGE_DLY)) rst_q[k] <= 1'b0;
                    if (seq_nxt == SEQ_W'(REL_CYCLES)) begin
                        state     <= RUN;
                        all_rel_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign b.pll_rst      = pll_rst_q;
    assign b.rst_out      = rst_q;
    assign b.all_released = all_rel_q;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_cnt;

    always_ff @(posedge clk_in1 or posedge reset)
        if (reset) loss_cnt <= '0;
        else if (loss && !(&loss_cnt)) loss_cnt <= loss_cnt + CNT_W'(1);

    assign b.lock_loss_cnt = loss_cnt;
`else
    assign b.lock_loss_cnt = CNT_W'(0);
`endif
endmodule
